// File: rtl/clock_pkg.sv
// Shared constants for the clock time-setting path: bus width, field wrap limits,
// controller state encoding and the edit_sel codes used for display blinking.
package clock_pkg;

  localparam int W = 6;

  localparam logic [W-1:0] HOUR_MAX = 6'd23;
  localparam logic [W-1:0] MIN_MAX  = 6'd59;
  localparam logic [W-1:0] SEC_MAX  = 6'd59;

  typedef enum logic [3:0] {
    ST_RUN     = 4'd0,
    ST_FETCH_H = 4'd1,
    ST_EDIT_H  = 4'd2,
    ST_WRITE_H = 4'd3,
    ST_FETCH_M = 4'd4,
    ST_EDIT_M  = 4'd5,
    ST_WRITE_M = 4'd6,
    ST_FETCH_S = 4'd7,
    ST_EDIT_S  = 4'd8,
    ST_WRITE_S = 4'd9
  } state_t;

  localparam logic [1:0] SEL_NONE = 2'd0;
  localparam logic [1:0] SEL_HOUR = 2'd1;
  localparam logic [1:0] SEL_MIN  = 2'd2;
  localparam logic [1:0] SEL_SEC  = 2'd3;

  function automatic logic [1:0] state_sel(input state_t s);
    case (s)
      ST_FETCH_H, ST_EDIT_H, ST_WRITE_H: return SEL_HOUR;
      ST_FETCH_M, ST_EDIT_M, ST_WRITE_M: return SEL_MIN;
      ST_FETCH_S, ST_EDIT_S, ST_WRITE_S: return SEL_SEC;
      default:                           return SEL_NONE;
    endcase
  endfunction

  function automatic logic [W-1:0] sel_max(input logic [1:0] sel);
    case (sel)
      SEL_HOUR: return HOUR_MAX;
      SEL_MIN:  return MIN_MAX;
      default:  return SEC_MAX;
    endcase
  endfunction

endpackage

// File: rtl/wrap_updown.sv
// Shadow register for the field being edited: loads from the databus, then steps
// up/down with wrap at a limit chosen at runtime by the controller.
module wrap_updown
  import clock_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_din,
  input  logic         i_inc,
  input  logic         i_dec,
  input  logic [W-1:0] i_max,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  // An out-of-range fetched value lands on the limit when stepped down and on 0 when stepped up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_din;
    end else if (i_inc && !i_dec) begin
      r_q <= (r_q >= i_max) ? '0 : r_q + 1'b1;
    end else if (i_dec && !i_inc) begin
      r_q <= (r_q == '0 || r_q > i_max) ? i_max : r_q - 1'b1;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/time_set_ctrl.sv
// Time-setting bus master: fetches hour/min/sec over the shared databus, lets the user
// adjust a shadow copy, and writes each field back with a one-cycle load strobe.
module time_set_ctrl
  import clock_pkg::*;
(
  input  logic         clk,
  input  logic         clear,
  input  logic         btn_mode,
  input  logic         btn_inc,
  input  logic         btn_dec,
  input  logic [W-1:0] databus,
  output logic         hour_en,
  output logic         min_en,
  output logic         sec_en,
  output logic         hour_load,
  output logic         min_load,
  output logic         sec_load,
  output logic [W-1:0] data,
  output logic         setting,
  output logic [1:0]   edit_sel
);

  state_t       r_state;
  state_t       w_state_next;
  logic         r_hour_en, r_min_en, r_sec_en;
  logic         r_hour_load, r_min_load, r_sec_load;
  logic         r_setting;
  logic [1:0]   r_edit_sel;
  logic         w_fetch;
  logic         w_edit;
  logic [W-1:0] w_shadow;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RUN:     if (btn_mode) w_state_next = ST_FETCH_H;
      ST_FETCH_H: w_state_next = ST_EDIT_H;
      ST_EDIT_H:  if (btn_mode) w_state_next = ST_WRITE_H;
      ST_WRITE_H: w_state_next = ST_FETCH_M;
      ST_FETCH_M: w_state_next = ST_EDIT_M;
      ST_EDIT_M:  if (btn_mode) w_state_next = ST_WRITE_M;
      ST_WRITE_M: w_state_next = ST_FETCH_S;
      ST_FETCH_S: w_state_next = ST_EDIT_S;
      ST_EDIT_S:  if (btn_mode) w_state_next = ST_WRITE_S;
      ST_WRITE_S: w_state_next = ST_RUN;
      default:    w_state_next = ST_RUN;
    endcase
  end

  // Outputs are decoded from the next state so they stay registered yet remain a pure function of state.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_state     <= ST_RUN;
      r_hour_en   <= 1'b0;
      r_min_en    <= 1'b0;
      r_sec_en    <= 1'b0;
      r_hour_load <= 1'b0;
      r_min_load  <= 1'b0;
      r_sec_load  <= 1'b0;
      r_setting   <= 1'b0;
      r_edit_sel  <= SEL_NONE;
    end else begin
      r_state     <= w_state_next;
      r_hour_en   <= (w_state_next == ST_FETCH_H);
      r_min_en    <= (w_state_next == ST_FETCH_M);
      r_sec_en    <= (w_state_next == ST_FETCH_S);
      r_hour_load <= (w_state_next == ST_WRITE_H);
      r_min_load  <= (w_state_next == ST_WRITE_M);
      r_sec_load  <= (w_state_next == ST_WRITE_S);
      r_setting   <= (w_state_next != ST_RUN);
      r_edit_sel  <= state_sel(w_state_next);
    end
  end

  assign w_fetch = r_state inside {ST_FETCH_H, ST_FETCH_M, ST_FETCH_S};
  // A mode press closes the edit, so any inc/dec arriving with it is dropped.
  assign w_edit  = (r_state inside {ST_EDIT_H, ST_EDIT_M, ST_EDIT_S}) && !btn_mode;

  wrap_updown u_shadow (
    .clk    (clk),
    .rst    (clear),
    .i_load (w_fetch),
    .i_din  (databus),
    .i_inc  (btn_inc & w_edit),
    .i_dec  (btn_dec & w_edit),
    .i_max  (sel_max(r_edit_sel)),
    .o_q    (w_shadow)
  );

  assign hour_en   = r_hour_en;
  assign min_en    = r_min_en;
  assign sec_en    = r_sec_en;
  assign hour_load = r_hour_load;
  assign min_load  = r_min_load;
  assign sec_load  = r_sec_load;
  assign setting   = r_setting;
  assign edit_sel  = r_edit_sel;
  assign data      = w_shadow;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Randomized bench for time_set_ctrl against a step-list reference model of the set sequence.
module tb_time_set_ctrl;
  import clock_pkg::*;

  logic         clk = 1'b0;
  logic         clear = 1'b1;
  logic         btn_mode = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0;
  logic [W-1:0] databus = '0;
  logic         hour_en, min_en, sec_en, hour_load, min_load, sec_load, setting;
  logic [W-1:0] data;
  logic [1:0]   edit_sel;

  time_set_ctrl dut (
    .clk(clk), .clear(clear), .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec),
    .databus(databus), .hour_en(hour_en), .min_en(min_en), .sec_en(sec_en),
    .hour_load(hour_load), .min_load(min_load), .sec_load(sec_load),
    .data(data), .setting(setting), .edit_sel(edit_sel)
  );

  always #5 clk = ~clk;

  logic [16:0] dut_outs;
  logic [5:0]  dut_strobes;
  assign dut_strobes = {hour_en, min_en, sec_en, hour_load, min_load, sec_load};
  assign dut_outs    = {dut_strobes, setting, edit_sel, data};

  int n_vec = 0;
  int n_err = 0;

  // Model: position in the 10-step set sequence (0 = running) plus shadow value.
  int m_pos = 0;
  int m_shadow = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int field_of(input int pos);
    return (pos == 0) ? 0 : (pos - 1) / 3 + 1;
  endfunction

  function automatic int kind_of(input int pos);  // 0 fetch, 1 edit, 2 write
    return (pos == 0) ? -1 : (pos - 1) % 3;
  endfunction

  function automatic int max_of(input int f);
    return (f == 1) ? 23 : 59;
  endfunction

  function automatic logic [16:0] model_outs();
    logic [2:0] en, ld;
    int f, k;
    logic [1:0] sel;
    logic [5:0] sh;
    en = '0;
    ld = '0;
    f = field_of(m_pos);
    k = kind_of(m_pos);
    if (k == 0) en[3-f] = 1'b1;
    if (k == 2) ld[3-f] = 1'b1;
    sel = f[1:0];
    sh = m_shadow[5:0];
    return {en, ld, (m_pos != 0), sel, sh};
  endfunction

  task automatic model_step(input logic m, input logic i, input logic d, input int bus);
    int f, mx;
    f = field_of(m_pos);
    mx = max_of(f);
    case (kind_of(m_pos))
      -1: if (m) m_pos = 1;
      0: begin m_shadow = bus; m_pos++; end
      1: begin
        if (m) m_pos++;
        else if (i && !d) m_shadow = (m_shadow > mx) ? 0 : (m_shadow + 1) % (mx + 1);
        else if (d && !i) m_shadow = (m_shadow > mx) ? mx : (m_shadow + mx) % (mx + 1);
      end
      default: m_pos = (m_pos == 9) ? 0 : m_pos + 1;
    endcase
  endtask

  // One clock: check outputs for the current step, then drive inputs sampled at the next edge.
  task automatic cycle(input logic m, input logic i, input logic d, input int bus_force);
    int bus;
    @(negedge clk);
    check_val("outs", dut_outs, model_outs());
    check_val("onehot", ($countones(dut_strobes) <= 1), 1);
    bus = 0;
    if (kind_of(m_pos) == 0) begin
      if (bus_force >= 0) bus = bus_force;
      else if ($urandom_range(0, 7) == 0) bus = $urandom_range(0, 63);
      else bus = $urandom_range(0, max_of(field_of(m_pos)));
    end
    btn_mode = m;
    btn_inc  = i;
    btn_dec  = d;
    databus  = bus[W-1:0];
    $display("cyc pos=%0d mode=%0b inc=%0b dec=%0b bus=%0d data=%0d", m_pos, m, i, d, bus, data);
    model_step(m, i, d, bus);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #3;
    check_val("reset_outs", dut_outs, 0);
    @(negedge clk);
    clear = 1'b0;
    m_pos = 0;
    m_shadow = 0;

    // Fetch 17 into hour, step up to 20, then wrap 23 -> 0.
    cycle(1, 0, 0, -1);
    cycle(0, 0, 0, 17);
    repeat (3) cycle(0, 1, 0, -1);
    after_edge();
    check_val("hour_inc3", data, 20);
    repeat (3) cycle(0, 1, 0, -1);
    cycle(0, 1, 0, -1);
    after_edge();
    check_val("hour_wrap", data, 0);
    cycle(1, 0, 0, -1);
    cycle(0, 1, 1, -1);
    // Minute: 0 - 1 -> 59, simultaneous inc/dec holds, mode with inc loads unincremented.
    cycle(0, 0, 0, 0);
    cycle(0, 0, 1, -1);
    after_edge();
    check_val("min_wrap", data, 59);
    cycle(0, 1, 1, -1);
    cycle(1, 1, 0, -1);
    after_edge();
    check_val("min_load", min_load, 1);
    check_val("min_data", data, 59);
    cycle(0, 1, 0, -1);
    cycle(0, 0, 0, 59);
    cycle(0, 1, 0, -1);
    after_edge();
    check_val("sec_wrap", data, 0);
    cycle(1, 0, 0, -1);
    cycle(0, 0, 1, -1);
    after_edge();
    check_val("run_setting", setting, 0);

    // Plain full pass: loads carry the fetched values.
    cycle(1, 0, 0, -1);
    cycle(0, 0, 0, 5);
    cycle(1, 0, 0, -1);
    cycle(0, 0, 0, -1);
    cycle(0, 0, 0, 33);
    cycle(1, 0, 0, -1);
    cycle(0, 0, 0, -1);
    cycle(0, 0, 0, 47);
    cycle(1, 0, 0, -1);
    cycle(0, 0, 0, -1);
    cycle(0, 0, 0, -1);

    // Random button traffic, including out-of-range fetched values.
    for (int n = 0; n < 600; n++) begin
      cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 2) == 0), -1);
    end

    // Abandon an edit of the minute field with clear.
    for (int b = 0; b < 20 && m_pos != 5; b++) cycle(1, 0, 0, -1);
    check_val("reach_edit_m", m_pos, 5);
    @(negedge clk);
    check_val("pre_clear", dut_outs, model_outs());
    btn_mode = 1'b0;
    btn_inc  = 1'b1;
    btn_dec  = 1'b0;
    #2 clear = 1'b1;
    #1;
    check_val("clear_async", dut_outs, 0);
    @(negedge clk);
    check_val("clear_hold", dut_outs, 0);
    clear = 1'b0;
    btn_inc = 1'b0;
    m_pos = 0;
    m_shadow = 0;
    for (int n = 0; n < 6; n++) begin
      cycle(0, ($urandom_range(0, 1) == 1), 0, -1);
      after_edge();
      check_val("no_min_load", min_load, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
